// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, receive FSM states and byte-wise CRC-32 helpers.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_t;

  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Ethernet sends LSB first, so the register runs in reflected (LSB-first) form.
  localparam logic [31:0] CRC32_POLY_REFL = bitrev32(CRC32_POLY);

  function automatic logic [31:0] crc32_d8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC32_POLY_REFL) : (r >> 1);
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide reflected CRC-32 register; shared by the GMII RX deframer and TX framer.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)   crc <= CRC32_INIT;
    else if (init) crc <= CRC32_INIT;
    else if (en)   crc <= crc32_d8(crc, d);
  end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD/FCS, flags bad frames at eop.
// Optional frame statistics counters are enabled with `define GMII_RX_STATS_EN.
module gmii_rx_deframer
  import eth_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [7:0]  rxd,
  input  logic        rxdv,
  input  logic        rxer,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err
`ifdef GMII_RX_STATS_EN
  ,
  output logic [31:0] stat_ok,
  output logic [31:0] stat_err
`endif
);

  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] CNT_SAT = 11'h7FF;
  localparam logic [10:0] DL_FULL = 11'd5;

  logic [7:0]  r_rxd;
  logic        r_rxdv;
  logic        r_rxer;
  rx_state_t   r_state;
  logic [39:0] r_dl;
  logic [10:0] r_cnt;
  logic        r_first;
  logic        r_bad;

  logic        w_sfd;
  logic        w_crc_en;
  logic        w_full;
  logic        w_err;
  logic [31:0] w_crc;

  assign w_sfd    = (r_state == ST_PREAMBLE) && r_rxdv && (r_rxd == ETH_SFD);
  assign w_crc_en = (r_state == ST_DATA) && r_rxdv;
  assign w_full   = (r_cnt >= DL_FULL);
  assign w_err    = r_bad || (bitrev32(w_crc) != CRC32_RESIDUE) ||
                    (r_cnt < MIN_L) || (r_cnt > MAX_L);

  eth_crc32_d8 u_crc (
    .clk    (clk),
    .arst_n (arst_n),
    .init   (w_sfd),
    .en     (w_crc_en),
    .d      (r_rxd),
    .crc    (w_crc)
  );

  // GMII inputs are registered once; the FSM works on the registered copy.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rxd     <= 8'h00;
      r_rxdv    <= 1'b0;
      r_rxer    <= 1'b0;
      r_state   <= ST_IDLE;
      r_dl      <= 40'h0;
      r_cnt     <= 11'd0;
      r_first   <= 1'b0;
      r_bad     <= 1'b0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
`ifdef GMII_RX_STATS_EN
      stat_ok   <= 32'd0;
      stat_err  <= 32'd0;
`endif
    end else begin
      r_rxd     <= rxd;
      r_rxdv    <= rxdv;
      r_rxer    <= rxer;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_rxdv) r_state <= (r_rxd == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
        end
        ST_PREAMBLE: begin
          if (!r_rxdv) begin
            r_state <= ST_IDLE;
          end else if (r_rxd == ETH_SFD) begin
            r_state <= ST_DATA;
            r_dl    <= 40'h0;
            r_cnt   <= 11'd0;
            r_first <= 1'b1;
            r_bad   <= 1'b0;
          end else if (r_rxd != ETH_PREAMBLE) begin
            r_state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (r_rxdv) begin
            r_dl <= {r_dl[31:0], r_rxd};
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 11'd1;
            if (r_rxer) r_bad <= 1'b1;
            // Once five bytes are held, the byte falling off the end is payload, never FCS.
            if (w_full) begin
              out_data  <= r_dl[39:32];
              out_valid <= 1'b1;
              out_sop   <= r_first;
              r_first   <= 1'b0;
            end
          end else begin
            r_state <= ST_IDLE;
            if (w_full) begin
              out_data  <= r_dl[39:32];
              out_valid <= 1'b1;
              out_sop   <= r_first;
              out_eop   <= 1'b1;
              out_err   <= w_err;
              r_first   <= 1'b0;
`ifdef GMII_RX_STATS_EN
              if (w_err) stat_err <= stat_err + 32'd1;
              else       stat_ok  <= stat_ok + 32'd1;
`endif
            end
          end
        end
        ST_DROP: begin
          if (!r_rxdv) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Self-checking bench for gmii_rx_deframer: table of frame scenarios, hand sequences, random frames.
module tb_gmii_rx_deframer;

  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 64;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic       rxdv = 1'b0;
  logic       rxer = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_sop, out_eop, out_err;
`ifdef GMII_RX_STATS_EN
  logic [31:0] stat_ok, stat_err;
  int exp_ok_n = 0, exp_err_n = 0;
`endif

  gmii_rx_deframer #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rxd       (rxd),
    .rxdv      (rxdv),
    .rxer      (rxer),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_err   (out_err)
`ifdef GMII_RX_STATS_EN
    ,
    .stat_ok   (stat_ok),
    .stat_err  (stat_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
  } ev_t;

  typedef struct {
    int         pre;
    int         pay;
    bit         rnd;
    logic [7:0] fxor;
    int         rxer_at;
    int         exp_n;
    bit         exp_err;
  } vec_t;

  int   checks = 0, errors = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;
  logic [7:0] stim_d[$];
  logic       stim_e[$];
  int   pay0, drv_cyc;
  bit   model_off = 1'b0;
  int   obs_n, obs_eops, sop_cyc;
  logic obs_err;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Observed stream: every emitted byte is matched against the reference queue.
  always @(negedge clk) begin
    if (!out_valid) begin
      checks++;
      if (out_data !== 8'h00) begin
        errors++;
        $display("FAIL idle_data actual=%h required=00", out_data);
      end
    end else begin
      obs_n++;
      if (out_sop) sop_cyc = cyc;
      if (out_eop) begin
        obs_eops++;
        obs_err = out_err;
      end
      if (!model_off) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte actual=%h required=none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e.d || out_sop !== mon_e.sop || out_eop !== mon_e.eop ||
              (mon_e.eop && out_err !== mon_e.err)) begin
            errors++;
            $display("FAIL stream_byte actual=d%h sop%b eop%b err%b required=d%h sop%b eop%b err%b",
                     out_data, out_sop, out_eop, out_err, mon_e.d, mon_e.sop, mon_e.eop, mon_e.err);
          end
        end
      end
    end
  end

  function automatic logic [31:0] crc32(input int from, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = from; i < from + n; i++) begin
      c ^= {24'h0, stim_d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build(input int pre, input int pay, input bit rnd, input logic [7:0] fxor,
                       input int rxer_at, input bit badpre);
    logic [31:0] fcs;
    stim_d.delete();
    stim_e.delete();
    if (badpre) begin
      stim_d.push_back(8'h55); stim_d.push_back(8'h55); stim_d.push_back(8'h57);
      repeat (3) stim_e.push_back(1'b0);
    end else begin
      repeat (pre) begin stim_d.push_back(8'h55); stim_e.push_back(1'b0); end
    end
    stim_d.push_back(8'hD5); stim_e.push_back(1'b0);
    pay0 = stim_d.size();
    for (int i = 0; i < pay; i++) begin
      stim_d.push_back(rnd ? 8'($urandom) : 8'(i));
      stim_e.push_back(i == rxer_at);
    end
    fcs = ~crc32(pay0, pay);
    for (int k = 0; k < 4; k++) begin
      stim_d.push_back(fcs[8*k +: 8] ^ ((k == 3) ? fxor : 8'h00));
      stim_e.push_back(1'b0);
    end
  endtask

  // Reference: frame = 0x55 run, 0xD5, then bytes until rxdv drops; last four are FCS.
  function automatic void model();
    int n, i, s, m;
    bit er, bad;
    logic [31:0] fcs_rx;
    ev_t e;
    n = stim_d.size();
    i = 0;
    while (i < n && stim_d[i] == 8'h55) i++;
    if (i == 0 || i >= n || stim_d[i] != 8'hD5) return;
    s = i + 1;
    m = n - s;
    if (m < 5) return;
    er = 1'b0;
    for (int j = s; j < n; j++) er |= stim_e[j];
    fcs_rx = {stim_d[n-1], stim_d[n-2], stim_d[n-3], stim_d[n-4]};
    bad = er || (fcs_rx != ~crc32(s, m - 4)) || (m < MIN_LEN) || (m > MAX_LEN);
    for (int k = 0; k <= m - 5; k++) begin
      e.d   = stim_d[s+k];
      e.sop = (k == 0);
      e.eop = (k == m - 5);
      e.err = (k == m - 5) ? bad : 1'b0;
      exp_q.push_back(e);
    end
`ifdef GMII_RX_STATS_EN
    if (bad) exp_err_n++;
    else     exp_ok_n++;
`endif
  endfunction

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge clk);
    #1;
    rxdv = dv;
    rxd  = d;
    rxer = er;
  endtask

  task automatic send(input int gap);
    if (!model_off) model();
    for (int i = 0; i < stim_d.size(); i++) begin
      drive(1'b1, stim_d[i], stim_e[i]);
      if (i == pay0) drv_cyc = cyc;
    end
    repeat (gap) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_obs();
    obs_n    = 0;
    obs_eops = 0;
    obs_err  = 1'b0;
    sop_cyc  = -1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_sop"},   32'(out_sop),   32'd0);
    chk({tag, "_eop"},   32'(out_eop),   32'd0);
    chk({tag, "_err"},   32'(out_err),   32'd0);
  endtask

  initial begin
    //            pre  pay   rnd   fxor   rxer  exp_n err
    tbl[0] = '{7,   60,   1'b0, 8'h00, -1,   60,   1'b0};
    tbl[1] = '{7,   60,   1'b0, 8'h01, -1,   60,   1'b1};
    tbl[2] = '{1,   20,   1'b0, 8'h00, -1,   20,   1'b1};
    tbl[3] = '{7,   60,   1'b1, 8'h00, 10,   60,   1'b1};
    tbl[4] = '{7,   0,    1'b0, 8'h00, -1,   0,    1'b0};
    tbl[5] = '{7,   1,    1'b0, 8'h00, -1,   1,    1'b1};
    tbl[6] = '{7,   1514, 1'b1, 8'h00, -1,   1514, 1'b0};
    tbl[7] = '{7,   1515, 1'b1, 8'h00, -1,   1515, 1'b1};
    tbl[8] = '{3,   1600, 1'b1, 8'h00, -1,   1600, 1'b1};

    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(posedge clk);
    #1 arst_n = 1'b1;

    for (int t = 0; t < 9; t++) begin
      clear_obs();
      build(tbl[t].pre, tbl[t].pay, tbl[t].rnd, tbl[t].fxor, tbl[t].rxer_at, 1'b0);
      send(12);
      chk($sformatf("tbl%0d_bytes", t), obs_n, tbl[t].exp_n);
      chk($sformatf("tbl%0d_eops", t), obs_eops, (tbl[t].exp_n > 0) ? 1 : 0);
      if (tbl[t].exp_n > 0) begin
        chk($sformatf("tbl%0d_err", t), 32'(obs_err), 32'(tbl[t].exp_err));
        chk($sformatf("tbl%0d_latency", t), sop_cyc - (drv_cyc + 1), 6);
      end
      chk($sformatf("tbl%0d_drained", t), exp_q.size(), 0);
    end

    // Broken preamble is dropped; the following good frame after one idle cycle survives.
    clear_obs();
    build(0, 60, 1'b0, 8'h00, -1, 1'b1);
    send(1);
    build(7, 60, 1'b1, 8'h00, -1, 1'b0);
    send(12);
    chk("badpre_eops", obs_eops, 1);
    chk("badpre_bytes", obs_n, 60);
    chk("badpre_err", 32'(obs_err), 0);

    // Back-to-back frames with a single idle cycle between them.
    clear_obs();
    build(7, 60, 1'b1, 8'h00, -1, 1'b0);
    send(1);
    build(7, 60, 1'b1, 8'h00, -1, 1'b0);
    send(12);
    chk("b2b_eops", obs_eops, 2);
    chk("b2b_bytes", obs_n, 120);

    // Reset during payload byte 30 for two cycles: frame abandoned, tail dropped.
    model_off = 1'b1;
    build(7, 60, 1'b0, 8'h00, -1, 1'b0);
    for (int i = 0; i < stim_d.size(); i++) begin
      drive(1'b1, stim_d[i], stim_e[i]);
      if (i == pay0 + 30) begin
        arst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        clear_obs();
`ifdef GMII_RX_STATS_EN
        exp_ok_n  = 0;
        exp_err_n = 0;
`endif
      end
      if (i == pay0 + 32) arst_n = 1'b1;
    end
    repeat (12) drive(1'b0, 8'h00, 1'b0);
    chk("midrst_bytes", obs_n, 0);
    chk("midrst_eops", obs_eops, 0);
    model_off = 1'b0;

    clear_obs();
    build(7, 60, 1'b0, 8'h00, 10, 1'b0);
    send(12);
    chk("rxer_bytes", obs_n, 60);
    chk("rxer_err", 32'(obs_err), 1);
`ifdef GMII_RX_STATS_EN
    chk("stat_err_after_rxer", stat_err, 1);
    chk("stat_ok_after_rxer", stat_ok, 0);
`endif

    clear_obs();
    build(7, 60, 1'b0, 8'h00, -1, 1'b0);
    send(12);
    chk("postrst_bytes", obs_n, 60);
    chk("postrst_err", 32'(obs_err), 0);

    for (int r = 0; r < 30; r++) begin
      int pay;
      pay = $urandom_range(0, 100);
      build($urandom_range(1, 7), pay, 1'b1,
            ($urandom % 4 == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
            ($urandom % 8 == 0) ? $urandom_range(0, pay) : -1,
            ($urandom % 8 == 0));
      send($urandom_range(1, 3));
    end
    repeat (12) drive(1'b0, 8'h00, 1'b0);
    chk("random_drained", exp_q.size(), 0);
`ifdef GMII_RX_STATS_EN
    chk("stat_ok_final", stat_ok, exp_ok_n);
    chk("stat_err_final", stat_err, exp_err_n);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
